// File: rtl/zbt_frame_arbiter.sv
// zbt_frame_arbiter
//   Shares the single ZBT SRAM port between the NTSC capture write stream and
//   the VGA display read stream. It also double-buffers whole frames, using the
//   ZBT address MSB as the frame-buffer select.
//
//   Captured words are queued in a small write FIFO. Display reads win
//   arbitration, but a read-run limit forces a write through so the FIFO cannot
//   starve. Issue is registered. Read data returns READ_LAT cycles after issue
//   and is passed straight through to the display, with a matching valid pipe.
//   The downstream pin driver applies the ZBT two-cycle write-data delay.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   ntsc_we/addr/data     one capture word per ntsc_we pulse (back buffer)
//   ntsc_frame            capture frame parity; each toggle marks a completed frame
//   vga_req/addr          display read request (front buffer)
//   vga_gnt               read issued this cycle (combinational)
//   vga_rvalid/rdata      returned read data
//   zbt_we/addr/din       registered ZBT command
//   zbt_dout              ZBT read data
//   disp_frame_start      display vertical-blank pulse; the only point where buffers swap
//   front_buf             buffer being displayed
//   fifo_overflow         sticky, set when a capture word was dropped
//   drop_count            saturating count of captured frames never displayed
module zbt_frame_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4,
    parameter int READ_LAT   = 2,
    parameter int MAX_RD_RUN = 8,
    parameter int DATA_W     = 36
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ntsc_we,
    input  logic [ADDR_W-2:0] ntsc_addr,
    input  logic [DATA_W-1:0] ntsc_data,
    input  logic              ntsc_frame,
    input  logic              vga_req,
    input  logic [ADDR_W-2:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              zbt_we,
    output logic [ADDR_W-1:0] zbt_addr,
    output logic [DATA_W-1:0] zbt_din,
    input  logic [DATA_W-1:0] zbt_dout,
    input  logic              disp_frame_start,
    output logic              front_buf,
    output logic              fifo_overflow,
    output logic [7:0]        drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int RUN_W = $clog2(MAX_RD_RUN + 1);
    localparam int VLD_W = READ_LAT + 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        READY = 2'd2
    } buf_state_t;

    logic [ADDR_W-2:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;

    logic [RUN_W-1:0]  rd_run;
    logic              force_wr;
    logic              rd_go;
    logic [VLD_W-1:0]  rd_vld_sr;

    buf_state_t        state;
    buf_state_t        state_nxt;
    logic              frame_q;
    logic              frame_tgl;
    logic              swap;
    logic              drop_inc;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));

    // Grant priority: forced write at the run limit, then display read, then
    // a write whenever the FIFO holds data.
    assign force_wr = !fifo_empty && (rd_run == RUN_W'(MAX_RD_RUN));
    assign rd_go    = vga_req && !force_wr;
    assign pop      = !rd_go && !fifo_empty;

    // A full FIFO still takes a word if a pop frees a slot in the same cycle.
    assign push     = ntsc_we && (!fifo_full || pop);

    assign vga_gnt    = rd_go;
    assign vga_rvalid = rd_vld_sr[VLD_W-1];
    assign vga_rdata  = zbt_dout;
    assign frame_tgl  = ntsc_frame ^ frame_q;

    // FIFO storage is data only, so it is never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ntsc_addr;
            fifo_data[wr_ptr] <= ntsc_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
            else if (!push && pop)
                fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
            if (ntsc_we && !push) fifo_overflow <= 1'b1;
        end
    end

    // ---- issue stage: ZBT command register and read-valid pipe ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zbt_we    <= 1'b0;
            zbt_addr  <= '0;
            zbt_din   <= '0;
            rd_run    <= '0;
            rd_vld_sr <= '0;
        end else begin
            rd_vld_sr <= {rd_vld_sr[VLD_W-2:0], rd_go};
            if (rd_go) begin
                zbt_we   <= 1'b0;
                zbt_addr <= {front_buf, vga_addr};
                // A run only counts while a write is actually waiting.
                rd_run   <= fifo_empty ? '0 : rd_run + RUN_W'(1);
            end else if (pop) begin
                zbt_we   <= 1'b1;
                // The back buffer is sampled here, so a swap on this same edge
                // cannot redirect a word that is already popped.
                zbt_addr <= {~front_buf, fifo_addr[rd_ptr]};
                zbt_din  <= fifo_data[rd_ptr];
                rd_run   <= '0;
            end else begin
                zbt_we   <= 1'b0;
            end
        end
    end

    // Buffer FSM. A swap wins over a simultaneous toggle; the toggle then
    // means the new back buffer is already complete, so go straight to DRAIN.
    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            FILL: begin
                if (frame_tgl) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty && !ntsc_we) state_nxt = READY;
            end
            READY: begin
                if (disp_frame_start) begin
                    swap      = 1'b1;
                    state_nxt = frame_tgl ? DRAIN : FILL;
                end else if (frame_tgl) begin
                    drop_inc  = 1'b1;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FILL;
            frame_q    <= 1'b0;
            front_buf  <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            state     <= state_nxt;
            frame_q   <= ntsc_frame;
            front_buf <= front_buf ^ swap;
            if (drop_inc && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_zbt_frame_arbiter.sv
// tb_zbt_frame_arbiter
//   Bench for zbt_frame_arbiter. Each cycle is described by a vector record
//   that holds the inputs, the expected grant and the expected ZBT command.
//   Write data and read returns go through scoreboard queues.
//   A small SRAM model answers reads with a known function of the address.
module tb_zbt_frame_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ntsc_we = 1'b0;
    logic [17:0] ntsc_addr = '0;
    logic [35:0] ntsc_data = '0;
    logic        ntsc_frame = 1'b0;
    logic        vga_req = 1'b0;
    logic [17:0] vga_addr = '0;
    logic        vga_gnt;
    logic        vga_rvalid;
    logic [35:0] vga_rdata;
    logic        zbt_we;
    logic [18:0] zbt_addr;
    logic [35:0] zbt_din;
    logic [35:0] zbt_dout = '0;
    logic        disp_frame_start = 1'b0;
    logic        front_buf;
    logic        fifo_overflow;
    logic [7:0]  drop_count;

    zbt_frame_arbiter #(
        .ADDR_W(19), .FIFO_DEPTH(4), .READ_LAT(2), .MAX_RD_RUN(8), .DATA_W(36)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .ntsc_we(ntsc_we), .ntsc_addr(ntsc_addr), .ntsc_data(ntsc_data),
        .ntsc_frame(ntsc_frame),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .zbt_we(zbt_we), .zbt_addr(zbt_addr), .zbt_din(zbt_din), .zbt_dout(zbt_dout),
        .disp_frame_start(disp_frame_start), .front_buf(front_buf),
        .fifo_overflow(fifo_overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // SRAM model: the address seen in cycle i returns data in cycle i+2.
    function automatic logic [35:0] sram_word(input logic [18:0] a);
        return 36'h9A5C00000 ^ {17'd0, a};
    endfunction

    logic [18:0] sram_a1 = '0;
    always @(posedge clk) begin
        sram_a1  <= zbt_addr;
        zbt_dout <= sram_word(sram_a1);
    end

    typedef struct packed {
        logic        req;
        logic [17:0] vaddr;
        logic        we;
        logic [17:0] naddr;
        logic [35:0] ndata;
        logic        keep;
        logic        exp_gnt;
        logic        exp_zwe;
        logic [18:0] exp_zaddr;
    } vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        exp_fb = 1'b0;
    logic [18:0] last_za = '0;
    logic [35:0] wq[$];
    logic [35:0] rq_data[$];
    int          rq_cyc[$];
    vec_t        tbl [9];

    function automatic vec_t mk(input logic req, input logic [17:0] va, input logic we,
                                input logic [17:0] na, input logic [35:0] nd, input logic keep,
                                input logic eg, input logic ezwe, input logic [18:0] eza);
        vec_t v;
        v.req = req; v.vaddr = va; v.we = we; v.naddr = na; v.ndata = nd;
        v.keep = keep; v.exp_gnt = eg; v.exp_zwe = ezwe; v.exp_zaddr = eza;
        return v;
    endfunction

    function automatic vec_t idle_v();
        return mk(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, last_za);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got an output with nothing queued, expected none (t=%0t)", name, $time);
    endtask

    // Applies one vector: drive inputs, check the combinational grant, clock,
    // then check the registered command and any returns.
    task automatic step(input vec_t v);
        vga_req   = v.req;
        vga_addr  = v.vaddr;
        ntsc_we   = v.we;
        ntsc_addr = v.naddr;
        ntsc_data = v.ndata;
        #1;
        chk("vga_gnt", vga_gnt, v.exp_gnt);
        if (v.exp_gnt) begin
            rq_data.push_back(sram_word({exp_fb, v.vaddr}));
            rq_cyc.push_back(cyc);
        end
        if (v.we && v.keep) wq.push_back(v.ndata);
        @(posedge clk);
        cyc++;
        #1;
        vga_req = 1'b0;
        ntsc_we = 1'b0;
        disp_frame_start = 1'b0;
        chk("zbt_we", zbt_we, v.exp_zwe);
        chk("zbt_addr", zbt_addr, v.exp_zaddr);
        last_za = v.exp_zaddr;
        if (zbt_we) begin
            if (wq.size() == 0) fail_now("zbt_din_extra_write");
            else chk("zbt_din", zbt_din, wq.pop_front());
        end
        if (rq_cyc.size() == 0) begin
            chk("vga_rvalid_spurious", vga_rvalid, 1'b0);
        end else if (vga_rvalid) begin
            chk("vga_rdata", vga_rdata, rq_data.pop_front());
            chk("read_latency", cyc - rq_cyc.pop_front(), 3);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        // reset state
        #1;
        chk("rst_vga_gnt", vga_gnt, 0);
        chk("rst_vga_rvalid", vga_rvalid, 0);
        chk("rst_zbt_we", zbt_we, 0);
        chk("rst_zbt_addr", zbt_addr, 0);
        chk("rst_zbt_din", zbt_din, 0);
        chk("rst_front_buf", front_buf, 0);
        chk("rst_fifo_overflow", fifo_overflow, 0);
        chk("rst_drop_count", drop_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // reads only, then writes only
        tbl[0] = mk(1, 18'h100, 0, 0, 0, 0, 1, 0, 19'h00100);
        tbl[1] = mk(1, 18'h101, 0, 0, 0, 0, 1, 0, 19'h00101);
        tbl[2] = mk(1, 18'h102, 0, 0, 0, 0, 1, 0, 19'h00102);
        tbl[3] = mk(0, 0,       0, 0, 0, 0, 0, 0, 19'h00102);
        tbl[4] = mk(0, 0, 1, 18'h5, 36'hC00000005, 1, 0, 0, 19'h00102);
        tbl[5] = mk(0, 0, 1, 18'h6, 36'hC00000006, 1, 0, 1, 19'h40005);
        tbl[6] = mk(0, 0, 1, 18'h7, 36'hC00000007, 1, 0, 1, 19'h40006);
        tbl[7] = mk(0, 0,       0, 0, 0, 0, 0, 1, 19'h40007);
        tbl[8] = mk(0, 0,       0, 0, 0, 0, 0, 0, 19'h40007);
        for (int i = 0; i < 9; i++) step(tbl[i]);
        chk("overflow_after_writes", fifo_overflow, 0);

        // starvation: one queued word, continuous reads
        step(mk(1, 18'h200, 1, 18'h11, 36'hC00000011, 1, 1, 0, 19'h00200));
        for (int i = 1; i <= 8; i++)
            step(mk(1, 18'(18'h200 + i), 0, 0, 0, 0, 1, 0, 19'(19'h00200 + i)));
        step(mk(1, 18'h209, 0, 0, 0, 0, 0, 1, 19'h40011));
        step(mk(1, 18'h209, 0, 0, 0, 0, 1, 0, 19'h00209));
        step(idle_v());

        // overflow: fifth push while reads hold the port
        for (int i = 0; i < 5; i++)
            step(mk(1, 18'(18'h300 + i), 1, 18'(18'h20 + i), 36'(36'hC00000020 + i),
                    (i < 4), 1, 0, 19'(19'h00300 + i)));
        chk("overflow_set", fifo_overflow, 1);
        for (int i = 0; i < 4; i++)
            step(mk(0, 0, 0, 0, 0, 0, 0, 1, 19'(19'h40020 + i)));
        step(idle_v());
        chk("overflow_sticky", fifo_overflow, 1);

        // buffer swap and frame drops
        disp_frame_start = 1'b1; step(idle_v());
        chk("start_ignored_in_fill", front_buf, 0);
        ntsc_frame = 1'b1; step(idle_v());
        step(idle_v());
        disp_frame_start = 1'b1; step(idle_v());
        exp_fb = 1'b1;
        chk("front_buf_swap", front_buf, 1);
        step(mk(1, 18'h40, 0, 0, 0, 0, 1, 0, 19'h40040));
        step(mk(0, 0, 1, 18'h33, 36'hC00000033, 1, 0, 0, 19'h40040));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 19'h00033));
        ntsc_frame = 1'b0; step(idle_v());
        step(idle_v());
        ntsc_frame = 1'b1; step(idle_v());
        chk("drop_count_one", drop_count, 1);
        chk("front_buf_held", front_buf, 1);
        ntsc_frame = 1'b0; disp_frame_start = 1'b1; step(idle_v());
        exp_fb = 1'b0;
        chk("swap_with_toggle", front_buf, 0);
        chk("drop_after_swap", drop_count, 1);
        step(idle_v());
        ntsc_frame = 1'b1; step(idle_v());
        chk("drop_count_two", drop_count, 2);
        disp_frame_start = 1'b1; step(idle_v());
        exp_fb = 1'b1;
        chk("front_buf_swap2", front_buf, 1);
        ntsc_frame = 1'b0; step(idle_v());
        disp_frame_start = 1'b1; step(idle_v());
        chk("no_swap_entering_ready", front_buf, 1);
        disp_frame_start = 1'b1; step(idle_v());
        exp_fb = 1'b0;
        chk("front_buf_swap3", front_buf, 0);

        // reset one cycle after a grant: the read must never return
        step(mk(1, 18'h55, 0, 0, 0, 0, 1, 0, 19'h00055));
        reset_n = 1'b0;
        rq_data.delete();
        rq_cyc.delete();
        #1;
        chk("midrst_vga_gnt", vga_gnt, 0);
        chk("midrst_zbt_we", zbt_we, 0);
        chk("midrst_zbt_addr", zbt_addr, 0);
        chk("midrst_zbt_din", zbt_din, 0);
        chk("midrst_front_buf", front_buf, 0);
        chk("midrst_fifo_overflow", fifo_overflow, 0);
        chk("midrst_drop_count", drop_count, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("midrst_vga_rvalid", vga_rvalid, 0);
        end
        reset_n = 1'b1;
        last_za = '0;
        exp_fb  = 1'b0;
        for (int i = 0; i < 5; i++) step(idle_v());

        chk("read_queue_drained", rq_cyc.size(), 0);
        chk("write_queue_drained", wq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
